// File: rtl/instr_feeder_if.sv
// -----------------------------------------------------------------------------
// instr_feeder_if
// Bundles the host-side load stream, the run controls and the CPU-facing pins
// of the instruction feeder.
//   slave  modport : the feeder itself (consumes load/start/clear/cpu_pc)
//   master modport : whoever drives the feeder (host logic or a testbench)
// Signals:
//   load_valid/load_data/load_ready : byte stream into program memory
//   start/clear                     : run request / return to idle and empty
//   cpu_pc                          : CPU output bus (PC while cpu_sel=0)
//   instr_out                       : 14-bit instruction presented to the CPU
//   cpu_sel/cpu_rst_n               : CPU output mux select, CPU reset (low)
//   prog_len                        : complete instructions loaded
//   running/done/timeout            : status flags
// -----------------------------------------------------------------------------
interface instr_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          load_valid;
    logic [7:0]    load_data;
    logic          load_ready;
    logic          start;
    logic          clear;
    logic [7:0]    cpu_pc;
    logic [13:0]   instr_out;
    logic          cpu_sel;
    logic          cpu_rst_n;
    logic [LW-1:0] prog_len;
    logic          running;
    logic          done;
    logic          timeout;

    modport slave (
        input  load_valid, load_data, start, clear, cpu_pc,
        output load_ready, instr_out, cpu_sel, cpu_rst_n, prog_len,
               running, done, timeout
    );

    modport master (
        output load_valid, load_data, start, clear, cpu_pc,
        input  load_ready, instr_out, cpu_sel, cpu_rst_n, prog_len,
               running, done, timeout
    );
endinterface

// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
// Host-side driver for the 8-bit common-bus CPU tile. A program is loaded as
// byte pairs (high byte, then low byte whose bits [7:2] complete the 14-bit
// word). While idle the CPU is held in reset; on start it gets a one-cycle
// reset pulse and is then served mem[cpu_pc/4] with one clock of latency.
// The run ends when the PC leaves the program or the cycle limit expires,
// after which the CPU output mux is switched to register view.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : instr_feeder_if.slave (load stream, controls, CPU pins, status)
// -----------------------------------------------------------------------------
module instr_feeder #(
    parameter int          DEPTH      = 16,
    parameter int          MAX_CYCLES = 1000,
    parameter logic [13:0] NOP_INSTR  = 14'h0000
) (
    input  logic           clock,
    input  logic           reset,
    instr_feeder_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH) + 1;   // wr_ptr / prog_len width
    localparam int MAW = $clog2(DEPTH);       // memory address width

    localparam logic [AW-1:0] DEPTH_L  = AW'(DEPTH);
    localparam logic [15:0]   CYC_LAST = 16'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [AW-1:0]  r_wr_ptr;
    logic           r_phase;
    logic [7:0]     r_hi;
    logic [15:0]    r_cycle_cnt;
    logic [13:0]    r_instr_out;
    logic           r_cpu_rst_n;
    logic           r_timeout;

    logic [13:0]    r_mem [DEPTH];

    logic           w_load_ready;
    logic           w_accept;
    logic [5:0]     w_idx;
    logic           w_in_prog;
    logic           w_end;
    logic           w_timeout_hit;
    logic           w_start_ok;
    logic           w_enter_run;
    logic [MAW-1:0] w_wr_addr;
    logic [MAW-1:0] w_rd_addr;
    logic           w_unused_bits;

    // Low two bits of the PC and of each low program byte carry no meaning.
    assign w_unused_bits = ^{bus.cpu_pc[1:0], bus.load_data[1:0]};

    assign w_idx     = bus.cpu_pc[7:2];
    assign w_wr_addr = r_wr_ptr[MAW-1:0];
    // Truncation is safe: the read is only used when idx < prog_len <= DEPTH.
    assign w_rd_addr = w_idx[MAW-1:0];
    assign w_in_prog = ({1'b0, w_idx} < 7'(r_wr_ptr));

    assign w_load_ready = (r_state == ST_IDLE) && (r_wr_ptr < DEPTH_L);
    assign w_accept     = bus.load_valid && w_load_ready && !bus.clear;

    // A start is only honoured on a complete, non-empty program with no byte
    // arriving in the same cycle.
    assign w_start_ok = bus.start && !bus.load_valid && !r_phase &&
                        (r_wr_ptr != '0);

    // End is only judged once the CPU is out of reset, so the PC it shows
    // during the reset pulse cannot terminate the run.
    assign w_end         = (r_state == ST_RUN) && r_cpu_rst_n && !w_in_prog;
    assign w_timeout_hit = (r_state == ST_RUN) && (r_cycle_cnt == CYC_LAST) &&
                           !w_end;

    assign w_enter_run = (w_next_state == ST_RUN) && (r_state != ST_RUN);

    // ---------------------------------------------------------------- FSM: state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- FSM: next state
    always_comb begin
        w_next_state = r_state;
        if (bus.clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start_ok)              w_next_state = ST_RUN;
                ST_RUN:  if (w_end || w_timeout_hit)  w_next_state = ST_DONE;
                ST_DONE: if (bus.start)               w_next_state = ST_RUN;
                default:                              w_next_state = ST_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- FSM: outputs
    always_comb begin
        bus.load_ready = w_load_ready;
        bus.running    = (r_state == ST_RUN);
        bus.done       = (r_state == ST_DONE);
        bus.cpu_sel    = (r_state == ST_DONE);
        bus.timeout    = r_timeout;
        bus.prog_len   = r_wr_ptr;
        bus.instr_out  = r_instr_out;
        bus.cpu_rst_n  = r_cpu_rst_n;
    end

    // ------------------------------------------------------------------ datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_cycle_cnt <= 16'h0000;
            r_instr_out <= NOP_INSTR;
            r_cpu_rst_n <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            if (bus.clear) begin
                r_wr_ptr <= '0;
                r_phase  <= 1'b0;
            end else if (w_accept) begin
                if (!r_phase) begin
                    r_hi    <= bus.load_data;
                    r_phase <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_phase  <= 1'b0;
                end
            end

            if (w_enter_run) begin
                r_cycle_cnt <= 16'h0000;
            end else if ((r_state == ST_RUN) && (r_cycle_cnt != 16'hFFFF)) begin
                r_cycle_cnt <= r_cycle_cnt + 16'h0001;
            end

            // Fetch only while staying in RUN, so DONE/IDLE always show NOP.
            if ((r_state == ST_RUN) && (w_next_state == ST_RUN) && w_in_prog) begin
                r_instr_out <= r_mem[w_rd_addr];
            end else begin
                r_instr_out <= NOP_INSTR;
            end

            // Low for the first RUN cycle (reset pulse) and throughout IDLE;
            // high otherwise so the CPU keeps its state in DONE.
            r_cpu_rst_n <= (w_next_state != ST_IDLE) && !w_enter_run;

            if ((r_state == ST_RUN) && (w_next_state == ST_DONE)) begin
                r_timeout <= w_timeout_hit;
            end else if (w_next_state != ST_DONE) begin
                r_timeout <= 1'b0;
            end
        end
    end

    // Program memory write port (no reset so it maps onto block RAM).
    always_ff @(posedge clock) begin
        if (w_accept && r_phase) begin
            r_mem[w_wr_addr] <= {r_hi, bus.load_data[7:2]};
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// -----------------------------------------------------------------------------
// tb_instr_feeder
// Self-checking bench for instr_feeder (DEPTH=16, MAX_CYCLES=20). A byte-level
// model of the program memory predicts each fetch; expected instructions are
// queued when cpu_pc is driven and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_instr_feeder;
    localparam int          DEPTH      = 16;
    localparam int          MAX_CYCLES = 20;
    localparam logic [13:0] NOP        = 14'h0000;

    logic clock = 1'b0;
    logic reset;

    instr_feeder_if #(.DEPTH(DEPTH)) bus ();

    instr_feeder #(
        .DEPTH      (DEPTH),
        .MAX_CYCLES (MAX_CYCLES),
        .NOP_INSTR  (NOP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;

    logic [13:0] m_mem [DEPTH];
    int          m_len;
    bit          m_phase;
    logic [7:0]  m_hi;
    logic [13:0] sb_q [$];
    logic [13:0] exp_v;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [13:0] exp_instr(input logic [7:0] pc);
        int idx;
        idx = int'(pc[7:2]);
        return (idx < m_len) ? m_mem[idx] : NOP;
    endfunction

    task automatic model_clear;
        m_len   = 0;
        m_phase = 1'b0;
        sb_q.delete();
    endtask

    // Presents one byte for a cycle and predicts whether it is taken.
    task automatic send_byte(input logic [7:0] b);
        logic exp_rdy;
        exp_rdy        = (m_len < DEPTH);
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        checks++;
        if (bus.load_ready !== exp_rdy) begin
            errors++;
            $display("FAIL load_ready byte=%02h got=%0b exp=%0b", b, bus.load_ready, exp_rdy);
        end
        tick();
        bus.load_valid = 1'b0;
        if (exp_rdy) begin
            if (!m_phase) begin
                m_hi    = b;
                m_phase = 1'b1;
            end else begin
                m_mem[m_len] = {m_hi, b[7:2]};
                m_len++;
                m_phase = 1'b0;
            end
        end
        $display("byte %02h taken=%0b prog_len=%0d", b, exp_rdy, bus.prog_len);
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.cpu_pc     = 8'h00;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (bus.cpu_rst_n  !== 1'b0) begin errors++; $display("FAIL reset cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset load_ready got=%0b exp=1", bus.load_ready); end
        checks++; if (bus.prog_len   !== 5'd0) begin errors++; $display("FAIL reset prog_len got=%0d exp=0", bus.prog_len); end
        checks++; if (bus.instr_out  !== NOP)  begin errors++; $display("FAIL reset instr_out got=%04h exp=%04h", bus.instr_out, NOP); end
        checks++; if ({bus.cpu_sel, bus.running, bus.done, bus.timeout} !== 4'b0000) begin
            errors++; $display("FAIL reset flags got=%04b exp=0000", {bus.cpu_sel, bus.running, bus.done, bus.timeout});
        end
        // Start with an empty program must be ignored.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL empty_start running got=%0b exp=0", bus.running); end
    endtask

    task automatic test_load;
        logic [7:0] bytes [4];
        bytes = '{8'hA5, 8'hC4, 8'h12, 8'h38};
        for (int i = 0; i < 4; i++) send_byte(bytes[i]);
        checks++; if (bus.prog_len   !== 5'd2) begin errors++; $display("FAIL load prog_len got=%0d exp=2", bus.prog_len); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load load_ready got=%0b exp=1", bus.load_ready); end
    endtask

    task automatic test_run;
        bus.cpu_pc = 8'h00;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        checks++; if (bus.running   !== 1'b1) begin errors++; $display("FAIL run_entry running got=%0b exp=1", bus.running); end
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL run_entry cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.instr_out !== NOP)  begin errors++; $display("FAIL run_entry instr_out got=%04h exp=%04h", bus.instr_out, NOP); end
        for (int i = 0; i < 2; i++) begin
            bus.cpu_pc = 8'(i * 4);
            sb_q.push_back(exp_instr(bus.cpu_pc));
            tick();
            exp_v = sb_q.pop_front();
            checks++; if (bus.instr_out !== exp_v) begin errors++; $display("FAIL run_fetch pc=%02h got=%04h exp=%04h", bus.cpu_pc, bus.instr_out, exp_v); end
            checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL run_rst_n pc=%02h got=%0b exp=1", bus.cpu_pc, bus.cpu_rst_n); end
            $display("pc=%02h instr=%04h", bus.cpu_pc, bus.instr_out);
        end
    endtask

    task automatic test_end;
        bus.cpu_pc = 8'h08;
        tick();
        checks++; if (bus.done      !== 1'b1) begin errors++; $display("FAIL end done got=%0b exp=1", bus.done); end
        checks++; if (bus.timeout   !== 1'b0) begin errors++; $display("FAIL end timeout got=%0b exp=0", bus.timeout); end
        checks++; if (bus.cpu_sel   !== 1'b1) begin errors++; $display("FAIL end cpu_sel got=%0b exp=1", bus.cpu_sel); end
        checks++; if (bus.instr_out !== NOP)  begin errors++; $display("FAIL end instr_out got=%04h exp=%04h", bus.instr_out, NOP); end
        checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL end cpu_rst_n got=%0b exp=1", bus.cpu_rst_n); end
        checks++; if (bus.running   !== 1'b0) begin errors++; $display("FAIL end running got=%0b exp=0", bus.running); end
    endtask

    task automatic test_timeout;
        bus.cpu_pc = 8'h00;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        // Now in RUN cycle 1.
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL to_entry cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
        for (int c = 1; c < MAX_CYCLES; c++) begin
            sb_q.push_back(exp_instr(bus.cpu_pc));
            tick();
            exp_v = sb_q.pop_front();
            checks++; if (bus.instr_out !== exp_v) begin errors++; $display("FAIL to_fetch cycle=%0d got=%04h exp=%04h", c + 1, bus.instr_out, exp_v); end
        end
        // RUN cycle MAX_CYCLES: still running.
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL to_last running got=%0b exp=1", bus.running); end
        tick();
        checks++; if (bus.done      !== 1'b1) begin errors++; $display("FAIL to_done done got=%0b exp=1", bus.done); end
        checks++; if (bus.timeout   !== 1'b1) begin errors++; $display("FAIL to_done timeout got=%0b exp=1", bus.timeout); end
        checks++; if (bus.instr_out !== NOP)  begin errors++; $display("FAIL to_done instr_out got=%04h exp=%04h", bus.instr_out, NOP); end
        $display("timeout run ended done=%0b timeout=%0b", bus.done, bus.timeout);
        // Re-run from DONE: fresh reset pulse, timeout cleared.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.running   !== 1'b1) begin errors++; $display("FAIL rerun running got=%0b exp=1", bus.running); end
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL rerun cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.timeout   !== 1'b0) begin errors++; $display("FAIL rerun timeout got=%0b exp=0", bus.timeout); end
        tick();
        checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL rerun pulse got=%0b exp=1", bus.cpu_rst_n); end
        bus.cpu_pc = 8'h08;
        tick();
        checks++; if ({bus.done, bus.timeout} !== 2'b10) begin errors++; $display("FAIL rerun_end done,timeout got=%02b exp=10", {bus.done, bus.timeout}); end
    endtask

    task automatic test_clear;
        bus.clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        model_clear();
        checks++; if ({bus.running, bus.done, bus.cpu_sel} !== 3'b000) begin errors++; $display("FAIL clear flags got=%03b exp=000", {bus.running, bus.done, bus.cpu_sel}); end
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL clear load_ready got=%0b exp=1", bus.load_ready); end
        checks++; if (bus.prog_len   !== 5'd0) begin errors++; $display("FAIL clear prog_len got=%0d exp=0", bus.prog_len); end
        checks++; if (bus.cpu_rst_n  !== 1'b0) begin errors++; $display("FAIL clear cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
    endtask

    task automatic test_start_rules;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i * 8'h11));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL odd_start running got=%0b exp=0", bus.running); end
        bus.start = 1'b1;
        send_byte(8'h9C);
        bus.start = 1'b0;
        checks++; if (bus.running  !== 1'b0) begin errors++; $display("FAIL byte_start running got=%0b exp=0", bus.running); end
        checks++; if (bus.prog_len !== 5'(m_len)) begin errors++; $display("FAIL byte_start prog_len got=%0d exp=%0d", bus.prog_len, m_len); end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
    endtask

    task automatic test_full_and_reset;
        for (int i = 0; i < 2 * DEPTH; i++) send_byte(8'($urandom_range(0, 255)));
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL full load_ready got=%0b exp=0", bus.load_ready); end
        checks++; if (bus.prog_len   !== 5'd16) begin errors++; $display("FAIL full prog_len got=%0d exp=16", bus.prog_len); end
        send_byte(8'h77);
        checks++; if (bus.prog_len   !== 5'd16) begin errors++; $display("FAIL overflow prog_len got=%0d exp=16", bus.prog_len); end
        // Read back every entry through the CPU port, low PC bits randomised.
        bus.cpu_pc = 8'h00;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.cpu_pc = 8'((i * 4) | $urandom_range(0, 3));
            sb_q.push_back(exp_instr(bus.cpu_pc));
            tick();
            exp_v = sb_q.pop_front();
            checks++; if (bus.instr_out !== exp_v) begin errors++; $display("FAIL full_fetch pc=%02h got=%04h exp=%04h", bus.cpu_pc, bus.instr_out, exp_v); end
            $display("pc=%02h instr=%04h", bus.cpu_pc, bus.instr_out);
        end
        checks++; if (bus.cpu_rst_n !== 1'b1) begin errors++; $display("FAIL pre_reset cpu_rst_n got=%0b exp=1", bus.cpu_rst_n); end
        // Asynchronous reset mid-run, observed before the next clock edge.
        reset = 1'b1;
        #1;
        checks++; if (bus.cpu_rst_n !== 1'b0) begin errors++; $display("FAIL async_reset cpu_rst_n got=%0b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.running   !== 1'b0) begin errors++; $display("FAIL async_reset running got=%0b exp=0", bus.running); end
        checks++; if (bus.prog_len  !== 5'd0) begin errors++; $display("FAIL async_reset prog_len got=%0d exp=0", bus.prog_len); end
        tick();
        reset = 1'b0;
        model_clear();
        tick();
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL post_reset load_ready got=%0b exp=1", bus.load_ready); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run();
        test_end();
        test_timeout();
        test_clear();
        test_start_rules();
        test_full_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
